// File: rtl/cic_pkg.sv
// cic_pkg: types and the shared round/saturate helper used by the CIC
// decimator and interpolator stages.
//   rate_t   - decimation/interpolation ratio field
//   state_t  - rate-change FSM state
//   round_sat(din, iw, ow) - requantise a sign-extended iw-bit value to ow bits
package cic_pkg;

  localparam int CIC_RW = 8;

  typedef logic [CIC_RW-1:0] rate_t;

  typedef enum logic {
    RUN     = 1'b0,
    PENDING = 1'b1
  } state_t;

  // din holds an iw-bit signed value sign-extended to 64 bits. The result is
  // an ow-bit signed value sign-extended to 64 bits. Narrowing rounds half-up
  // and clips positive overflow (adding the rounding constant can only push
  // the value upwards); widening left-aligns the input.
  function automatic logic signed [63:0] round_sat(input logic signed [63:0] din,
                                                   input int iw, input int ow);
    logic signed [64:0] s;
    logic signed [64:0] maxv;
    if (ow >= iw) begin
      return din <<< (ow - iw);
    end
    s    = 65'(din) + (65'sd1 <<< (iw - ow - 1));
    s    = s >>> (iw - ow);
    maxv = (65'sd1 <<< (ow - 1)) - 65'sd1;
    if (s > maxv) begin
      return 64'(maxv);
    end
    return 64'(s);
  endfunction

endpackage

// File: rtl/cic_requant.sv
// cic_requant: purely combinational idw -> odw requantiser (round half-up,
// positive saturation when narrowing; sign-extended left-align when widening).
//   i_data  in   idw  signed sample
//   o_data  out  odw  signed requantised sample
module cic_requant
  import cic_pkg::*;
#(
  parameter int idw = 32,
  parameter int odw = 24
) (
  input  logic signed [idw-1:0] i_data,
  output logic signed [odw-1:0] o_data
);

  always_comb begin
    o_data = odw'(round_sat(64'(i_data), idw, odw));
  end

endmodule

// File: rtl/cic_decimator.sv
// cic_decimator: keeps one of every R valid integrator samples, requantises
// it to odw bits and strobes it into the comb cascade. R is reprogrammable;
// a new ratio is applied only when the current decimation period ends.
//   clk        in   1    system clock
//   reset_n    in   1    synchronous active-low reset
//   in_dv      in   1    data_in valid
//   data_in    in   idw  signed integrator output
//   rate       in   rw   requested ratio, sampled on rate_ld
//   rate_ld    in   1    ratio change request
//   rate_err   out  1    pulse: request with rate==0 was ignored
//   rate_busy  out  1    ratio change pending
//   out_dv     out  1    data_out valid strobe
//   data_out   out  odw  signed decimated sample
//
// state   | meaning
// RUN     | ratio fixed, no change outstanding
// PENDING | new ratio latched, applied at the end of the current period
module cic_decimator
  import cic_pkg::*;
#(
  parameter int idw   = 32,
  parameter int odw   = 24,
  parameter int rw    = CIC_RW,
  parameter int R_RST = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_dv,
  input  logic signed [idw-1:0] data_in,
  input  logic        [rw-1:0]  rate,
  input  logic                  rate_ld,
  output logic                  rate_err,
  output logic                  rate_busy,
  output logic                  out_dv,
  output logic signed [odw-1:0] data_out
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic        [rw-1:0]  r_cnt;
  logic        [rw-1:0]  r_rate;
  logic        [rw-1:0]  r_rate_new;
  logic                  r_rate_err;
  logic                  r_out_dv;
  logic signed [odw-1:0] r_data;
  logic signed [odw-1:0] w_requant;
  logic                  w_period_end;
  logic                  w_req_ok;
  logic                  w_req_bad;

  assign w_period_end = in_dv && (r_cnt == (r_rate - rw'(1)));
  assign w_req_ok     = rate_ld && (rate != '0);
  assign w_req_bad    = rate_ld && (rate == '0);

  cic_requant #(
    .idw (idw),
    .odw (odw)
  ) u_requant (
    .i_data (data_in),
    .o_data (w_requant)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A fresh request arriving on the very cycle a pending ratio is applied
  // stays queued for the following period.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (w_req_ok) w_state_nxt = PENDING;
      PENDING: if (w_period_end && !w_req_ok) w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  always_comb begin
    rate_busy = (r_state == PENDING);
    rate_err  = r_rate_err;
    out_dv    = r_out_dv;
    data_out  = r_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt      <= '0;
      r_rate     <= rw'(R_RST);
      r_rate_new <= rw'(R_RST);
      r_rate_err <= 1'b0;
      r_out_dv   <= 1'b0;
      r_data     <= '0;
    end else begin
      r_rate_err <= w_req_bad;
      r_out_dv   <= w_period_end;
      if (in_dv) begin
        r_cnt <= w_period_end ? '0 : r_cnt + rw'(1);
      end
      if (w_period_end) begin
        r_data <= w_requant;
      end
      if ((r_state == PENDING) && w_period_end) begin
        r_rate <= r_rate_new;
      end
      if (w_req_ok) begin
        r_rate_new <= rate;
      end
    end
  end

endmodule

// File: tb/tb_cic_decimator.sv
module tb_cic_decimator;
  import cic_pkg::*;

  localparam int RST_R = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_dv;
  logic [31:0] data_in;
  rate_t       rate;
  logic        rate_ld;

  logic        err_a, busy_a, dv_a;
  logic [31:0] dout_a;
  logic        err_b, busy_b, dv_b;
  logic [23:0] dout_b;

  always #5 clk = ~clk;

  cic_decimator #(.idw(32), .odw(32), .rw(8), .R_RST(RST_R)) u_dut_a (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_dv     (in_dv),
    .data_in   (data_in),
    .rate      (rate),
    .rate_ld   (rate_ld),
    .rate_err  (err_a),
    .rate_busy (busy_a),
    .out_dv    (dv_a),
    .data_out  (dout_a)
  );

  cic_decimator #(.idw(32), .odw(24), .rw(8), .R_RST(RST_R)) u_dut_b (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_dv     (in_dv),
    .data_in   (data_in),
    .rate      (rate),
    .rate_ld   (rate_ld),
    .rate_err  (err_b),
    .rate_busy (busy_b),
    .out_dv    (dv_b),
    .data_out  (dout_b)
  );

  typedef struct {
    logic [31:0] a;
    logic [23:0] b;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  int          m_cnt, m_r, m_rnew;
  logic        m_pend;
  logic        exp_dv, exp_err;
  logic [31:0] last_a;
  logic [23:0] last_b;

  function automatic logic [23:0] ref_b(input logic [31:0] d);
    logic [32:0] s;
    s = {d[31], d} + 33'h80;
    if (!s[32] && s[31]) return 24'h7FFFFF;
    return s[31:8];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    in_dv   = 1'b0;
    data_in = '0;
    rate    = '0;
    rate_ld = 1'b0;
    m_cnt   = 0;
    m_r     = RST_R;
    m_rnew  = RST_R;
    m_pend  = 1'b0;
    last_a  = '0;
    last_b  = '0;
    sb_q.delete();
    @(posedge clk);
    #1;
    chk("rst_out_dv",   {62'd0, dv_b, dv_a}, 64'd0);
    chk("rst_data_a",   dout_a, 64'd0);
    chk("rst_data_b",   dout_b, 64'd0);
    chk("rst_busy",     {62'd0, busy_b, busy_a}, 64'd0);
    chk("rst_err",      {62'd0, err_b, err_a}, 64'd0);
    reset_n = 1'b1;
  endtask

  task automatic step(input logic dv, input logic [31:0] din, input logic ld, input rate_t rt);
    logic pe;
    exp_t e;
    in_dv   = dv;
    data_in = din;
    rate_ld = ld;
    rate    = rt;

    exp_err = ld && (rt == 0);
    pe      = dv && (m_cnt == m_r - 1);
    exp_dv  = pe;
    if (pe) begin
      e.a = din;
      e.b = ref_b(din);
      sb_q.push_back(e);
    end
    if (dv) m_cnt = pe ? 0 : m_cnt + 1;
    if (m_pend && pe) begin
      m_r    = m_rnew;
      m_pend = 1'b0;
    end
    if (ld && rt != 0) begin
      m_rnew = int'(rt);
      m_pend = 1'b1;
    end

    @(posedge clk);
    #1;
    chk("out_dv_a",  dv_a, exp_dv);
    chk("out_dv_b",  dv_b, exp_dv);
    chk("rate_err",  err_a, exp_err);
    chk("rate_busy", busy_a, m_pend);
    if (dv_a) begin
      chk("sb_nonempty", sb_q.size() != 0, 1);
      if (sb_q.size() != 0) begin
        e      = sb_q.pop_front();
        last_a = e.a;
        last_b = e.b;
      end
    end
    chk("data_a", dout_a, last_a);
    chk("data_b", dout_b, last_b);
  endtask

  initial begin
    do_reset();

    // R=4 ramp: outputs 3, 7, 11
    for (int i = 0; i < 12; i++) step(1'b1, 32'(i), 1'b0, '0);
    chk("ramp_last", dout_a, 64'd11);

    // requantisation corners at period end
    for (int i = 0; i < 3; i++) step(1'b1, 32'h5, 1'b0, '0);
    step(1'b1, 32'h7FFFFF80, 1'b0, '0);
    chk("sat_pos", dout_b, 64'h7FFFFF);
    for (int i = 0; i < 3; i++) step(1'b1, 32'h5, 1'b0, '0);
    step(1'b1, 32'h00000180, 1'b0, '0);
    chk("round_180", dout_b, 64'h000002);
    for (int i = 0; i < 3; i++) step(1'b1, 32'h5, 1'b0, '0);
    step(1'b1, 32'hFFFFFF7F, 1'b0, '0);
    chk("round_neg", dout_b, 64'hFFFFFF);
    for (int i = 0; i < 3; i++) step(1'b1, 32'h5, 1'b0, '0);
    step(1'b1, 32'h80000000, 1'b0, '0);
    chk("most_neg", dout_b, 64'h800000);

    // rate change 4 -> 2 after the 2nd sample of a period
    step(1'b1, 32'd100, 1'b0, '0);
    step(1'b1, 32'd101, 1'b0, '0);
    step(1'b0, 32'd0, 1'b1, 8'd2);
    chk("busy_set", busy_a, 64'd1);
    step(1'b1, 32'd102, 1'b0, '0);
    step(1'b1, 32'd103, 1'b0, '0);
    chk("busy_fall", busy_a, 64'd0);
    chk("old_r_out", dout_a, 64'd103);
    for (int i = 0; i < 6; i++) step(1'b1, 32'(200 + i), 1'b0, '0);
    chk("new_r_out", dout_a, 64'd205);

    // rate==0 request is rejected, cadence stays at R=2
    step(1'b1, 32'd300, 1'b1, 8'd0);
    chk("err_pulse", err_a, 64'd1);
    step(1'b1, 32'd301, 1'b0, '0);
    chk("err_gone", err_a, 64'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 32'(310 + i), 1'b0, '0);

    // request on a period-ending sample: applies after the next full period
    step(1'b1, 32'd400, 1'b0, '0);
    step(1'b1, 32'd401, 1'b1, 8'd3);
    step(1'b1, 32'd402, 1'b0, '0);
    step(1'b1, 32'd403, 1'b0, '0);
    chk("queued_r", dout_a, 64'd403);

    // gapped input at R=3
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 32'($urandom), 1'b0, '0);
      step(1'b0, 32'($urandom), 1'b0, '0);
      step(1'b0, 32'($urandom), 1'b0, '0);
    end

    // reset with a change pending at cnt=2
    step(1'b0, 32'd0, 1'b1, 8'd5);
    step(1'b1, 32'd500, 1'b0, '0);
    step(1'b1, 32'd501, 1'b0, '0);
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 32'(600 + i), 1'b0, '0);
    chk("post_rst_r", dout_a, 64'd607);

    // R=1 pass-through with back-to-back strobes
    step(1'b0, 32'd0, 1'b1, 8'd1);
    for (int i = 0; i < 4; i++) step(1'b1, 32'(700 + i), 1'b0, '0);
    for (int i = 0; i < 5; i++) step(1'b1, 32'($urandom), 1'b0, '0);
    step(1'b0, 32'd0, 1'b0, '0);

    chk("sb_empty", sb_q.size(), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
